serial_deser: RTL
=================

# serial_deser

Serial-to-parallel deserializer that consumes the registered single-bit stream produced by the d_ff stage (`q` → `bit_in`). It assembles `WIDTH` accepted bits into a word and presents that word on a valid/ready output port. The output has a single holding register and reports overflow when a completed word cannot be stored. It sits directly downstream of d_ff and upstream of any word-wide consumer.

## Interface
- `WIDTH`, 8, data bits per word (≥2)
- `MSB_FIRST`, 1, 1: first accepted bit lands in `word_out[WIDTH-1]`; 0: first accepted bit lands in `word_out[0]`
- `clk` in 1: single clock; all logic uses the rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `bit_in` in 1: serial data, driven from d_ff `q`
- `bit_valid` in 1: `bit_in` is accepted on every rising edge where this is 1
- `word_out` out `WIDTH`: assembled word, stable while `word_valid`=1
- `word_valid` out 1: `word_out` holds an unconsumed word
- `word_ready` in 1: consumer accepts the word; transfer happens on an edge where `word_valid`=1 and `word_ready`=1
- `overflow` out 1: one-cycle pulse; a completed word was dropped
- `parity_err` out 1: sideband qualified by `word_valid`; always 0 without `PARITY_EN`

## Operation
- Reset values, applied when `rst_n`=0 at a rising edge: shift register 0, bit counter 0, FSM in `COLLECT`, `word_out`=0, `word_valid`=0, `overflow`=0, `parity_err`=0.
- A reset during a partial word discards the partial word. A reset while `word_valid`=1 drops the held word; it does not raise `overflow`.
- FSM states:
  - `COLLECT`: each accepted bit shifts in and the counter increments. When accepting data bit `WIDTH` completes the word, go to `PARITY` if `PARITY_EN`, else stay in `COLLECT`.
  - `PARITY`: the next accepted bit is the parity bit. The word completes on that bit; return to `COLLECT`.
- Bit counter width is `$clog2(WIDTH+1)`. It wraps to 0 on word completion, so no idle cycle is needed between words.
- While `bit_valid`=0, state, counter and shift register hold.
- On word completion, the output register has space if `word_valid`=0, or if `word_valid`=1 and `word_ready`=1 on that same edge:
  - With space: load the word into `word_out`; `word_valid` is 1 on the next cycle.
  - Without space: drop the new word, keep `word_out` unchanged, and pulse `overflow` for exactly one cycle.
- Handshake: `word_valid` falls after a transfer edge unless a new word loads on that same edge, in which case it stays 1.
- Collection continues while a word is held, so back-pressure never stalls input.

## Timing
- Latency: the last bit of a word (data bit `WIDTH`, or the parity bit) sampled at edge N gives `word_valid`=1 and new `word_out` in the cycle after N.
- Minimum word period is `WIDTH` cycles, or `WIDTH`+1 cycles with parity.
- Throughput: one word per word period when `word_ready` is tied to 1.
- `overflow` asserts in the cycle after the dropped word's last bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_DESER_PARITY_EN`.
- Defined:
  - The `PARITY` state is compiled in and one extra bit follows each word.
  - Even parity: `parity_err`=1 when the XOR of the `WIDTH` data bits and the parity bit equals 1.
  - `parity_err` is registered with `word_out` and follows the same load/hold/drop rules.
- Undefined:
  - No `PARITY` state; words are exactly `WIDTH` bits.
  - The `parity_err` port remains and is tied to 0.

## Structure
- Package `serial_deser_pkg` holds:
  - the state enum `deser_state_e` (`COLLECT`, `PARITY`);
  - a function returning the counter width for a given `WIDTH`.
- Sub-module `serial_deser_out_reg` is the one-entry holding register. It owns `word_out`, `word_valid`, `parity_err`, `overflow` and the space/load logic.
- The top level holds the FSM, the counter and the shift register.

## Test plan
- Reset: drive `rst_n`=0 for 2 edges with `bit_valid`=1 → all outputs 0 and counter 0.
- MSB first: with `MSB_FIRST`=1, stream 1,1,0,1,0,0,0,0 and `word_ready`=1 → `word_out`=8'hD0 and `word_valid` high for 1 cycle, one cycle after the 8th bit. With `MSB_FIRST`=0, the same stream → 8'h0B.
- Gaps: insert `bit_valid`=0 gaps between bits of 8'hA5 → same word, latency measured from the last accepted bit.
- Back-pressure: hold `word_ready`=0 and send 8'h11 then 8'h22 → `word_out` stays 8'h11 and `overflow` pulses once. Then raise `word_ready` with completion of 8'h33 on the same edge → 8'h33 loads and no overflow.
- Mid-word reset: send 5 bits, pulse `rst_n`=0 for one edge, then send a full 8'h5A → `word_out`=8'h5A.
- With `SERIAL_DESER_PARITY_EN`:
  - 8'hA5 plus parity bit 0 → `parity_err`=0.
  - 8'hA5 plus parity bit 1 → `parity_err`=1.
  - The word appears one cycle after the parity bit.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and sizing helpers for the serial_deser deserializer.
package serial_deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } deser_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_deser_out_reg.sv
// One-entry holding register for assembled words: valid/ready output,
// overflow pulse on a dropped word, parity_err carried alongside the word.
module serial_deser_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             perr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovf_q, ovf_d;
    logic             space_s;

    // A slot frees up on the same edge the current word is consumed.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovf_d   = 1'b0;
        space_s = !valid_q || ready_i;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (load_i && space_s) begin
            word_d  = word_i;
            perr_d  = perr_i;
            valid_d = 1'b1;
        end else if (load_i) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_o     = word_q;
    assign valid_o    = valid_q;
    assign perr_o     = perr_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with valid/ready word output.
// Optional even-parity bit per word enabled by SERIAL_DESER_PARITY_EN.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             parity_err
);

    localparam int CW = cnt_width(WIDTH);

    deser_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shifted_s;
    logic             last_data_s;
    logic             done_s;
    logic [WIDTH-1:0] done_word_s;
    logic             done_perr_s;

    // Shift direction decides whether the first bit ends up at the MSB or LSB.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_q[WIDTH-2:0], bit_in};
        end else begin
            shifted_s = {bit_in, shift_q[WIDTH-1:1]};
        end
    end

    assign last_data_s = (cnt_q == CW'(WIDTH - 1));

    // Next-state: collect data bits, then optionally one parity bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        done_s      = 1'b0;
        done_word_s = shift_q;
        done_perr_s = 1'b0;
        if (bit_valid) begin
            case (state_q)
                COLLECT: begin
                    shift_d = shifted_s;
                    if (last_data_s) begin
                        cnt_d = {CW{1'b0}};
`ifdef SERIAL_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        done_s      = 1'b1;
                        done_word_s = shifted_s;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    done_s      = 1'b1;
                    done_word_s = shift_q;
                    done_perr_s = (^shift_q) ^ bit_in;
                    state_d     = COLLECT;
                end
`endif
                default: begin
                    state_d = COLLECT;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= {CW{1'b0}};
            shift_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    serial_deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (done_s),
        .word_i     (done_word_s),
        .perr_i     (done_perr_s),
        .ready_i    (word_ready),
        .word_o     (word_out),
        .valid_o    (word_valid),
        .perr_o     (parity_err),
        .overflow_o (overflow)
    );

endmodule
